// File: rtl/series_ctrl_unit.sv
// Sequencer for the Taylor-series exponential datapath: INIT, then N_TERMS x (MUL, ADD), then OUT handshake.
// Optional macro SERIES_EARLY_EXIT_EN lets a zero term end the series early.
module series_ctrl_unit #(
  parameter int N_TERMS    = 8,
  parameter int CNT_W      = 3,
  parameter int MUL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out_ready,
  input  logic             term_zero,
  output logic             ldX,
  output logic             ldTmp,
  output logic             selTmp,
  output logic             clrRes,
  output logic             ldRes,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL,
    S_ADD,
    S_OUT
  } state_t;

  localparam logic [3:0]       WAIT_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(N_TERMS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [3:0]       wait_cnt, wait_nxt;
  logic             exit_now;

`ifdef SERIES_EARLY_EXIT_EN
  assign exit_now = term_zero;
`else
  logic unused_term_zero;
  assign unused_term_zero = term_zero;
  assign exit_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Strobes depend only on state and wait_cnt, both registered, so the outputs stay Moore.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wait_nxt  = wait_cnt;
    ldX       = 1'b0;
    ldTmp     = 1'b0;
    selTmp    = 1'b0;
    clrRes    = 1'b0;
    ldRes     = 1'b0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_INIT;
      end
      S_INIT: begin
        ldX       = 1'b1;
        clrRes    = 1'b1;
        ldTmp     = 1'b1;
        idx_nxt   = '0;
        wait_nxt  = '0;
        state_nxt = S_MUL;
      end
      S_MUL: begin
        if (wait_cnt == WAIT_LAST) begin
          ldTmp     = 1'b1;
          selTmp    = 1'b1;
          wait_nxt  = '0;
          state_nxt = S_ADD;
        end else begin
          wait_nxt = wait_cnt + 4'd1;
        end
      end
      S_ADD: begin
        ldRes = 1'b1;
        if (idx == IDX_LAST || exit_now) begin
          state_nxt = S_OUT;
        end else begin
          idx_nxt   = idx + CNT_W'(1);
          state_nxt = S_MUL;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign term_idx = idx;

endmodule

// File: tb/tb_series_ctrl_unit.sv
// Bench for series_ctrl_unit: two instances (8 terms/1-cycle multiply and 4 terms/3-cycle multiply)
// checked every cycle against a cycle-offset model of the series schedule.
module tb_series_ctrl_unit;

  localparam int NA = 8, MA = 1, NB = 4, MB = 3;
`ifdef SERIES_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, out_ready, term_zero;
  logic a_ldX, a_ldTmp, a_selTmp, a_clrRes, a_ldRes, a_busy, a_out_valid;
  logic b_ldX, b_ldTmp, b_selTmp, b_clrRes, b_ldRes, b_busy, b_out_valid;
  logic [2:0] a_term_idx, b_term_idx;

  series_ctrl_unit #(.N_TERMS(NA), .CNT_W(3), .MUL_CYCLES(MA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready), .term_zero(term_zero),
    .ldX(a_ldX), .ldTmp(a_ldTmp), .selTmp(a_selTmp), .clrRes(a_clrRes), .ldRes(a_ldRes),
    .term_idx(a_term_idx), .busy(a_busy), .out_valid(a_out_valid));

  series_ctrl_unit #(.N_TERMS(NB), .CNT_W(3), .MUL_CYCLES(MB)) dut_b (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready), .term_zero(term_zero),
    .ldX(b_ldX), .ldTmp(b_ldTmp), .selTmp(b_selTmp), .clrRes(b_clrRes), .ldRes(b_ldRes),
    .term_idx(b_term_idx), .busy(b_busy), .out_valid(b_out_valid));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: mode 0 idle, 1 running (kk = cycles since INIT), 2 waiting in OUT; midx = held term_idx.
  int mode[2];
  int kk[2];
  int midx[2];

  function automatic int n_of(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic int m_of(input int d);
    return (d == 0) ? MA : MB;
  endfunction

  // Flag order: {ldX, ldTmp, selTmp, clrRes, ldRes, busy, out_valid}
  function automatic void model_expect(input int d, output logic [6:0] fl, output int ix);
    int m, q, p;
    m  = m_of(d);
    fl = 7'b0000000;
    ix = midx[d];
    if (mode[d] == 1) begin
      if (kk[d] == 0) begin
        fl = 7'b1101010;
      end else begin
        q  = (kk[d] - 1) / (m + 1);
        p  = (kk[d] - 1) % (m + 1);
        ix = q;
        if (p < m) fl = (p == m - 1) ? 7'b0110010 : 7'b0000010;
        else       fl = 7'b0000110;
      end
    end else if (mode[d] == 2) begin
      fl = 7'b0000011;
    end
  endfunction

  task automatic model_update(input int d);
    int m, q, p;
    m = m_of(d);
    if (rst) begin
      mode[d] = 0;
      midx[d] = 0;
    end else if (mode[d] == 0) begin
      if (start) begin
        mode[d] = 1;
        kk[d]   = 0;
      end
    end else if (mode[d] == 1) begin
      if (kk[d] == 0) begin
        midx[d] = 0;
        kk[d]   = 1;
      end else begin
        q = (kk[d] - 1) / (m + 1);
        p = (kk[d] - 1) % (m + 1);
        if (p == m && (q == n_of(d) - 1 || (EARLY && term_zero))) begin
          mode[d] = 2;
          midx[d] = q;
        end else begin
          kk[d] = kk[d] + 1;
        end
      end
    end else if (out_ready) begin
      mode[d] = 0;
    end
  endtask

  task automatic checkOutput();
    logic [6:0] fl;
    int ix;
    logic [2:0] eix;
    model_expect(0, fl, ix);
    eix = 3'(ix);
    checks++;
    assert ({a_ldX, a_ldTmp, a_selTmp, a_clrRes, a_ldRes, a_busy, a_out_valid} === fl) else begin
      errors++;
      $error("[TB] FAIL a_flags cyc=%0d observed=%b expected=%b", cyc,
             {a_ldX, a_ldTmp, a_selTmp, a_clrRes, a_ldRes, a_busy, a_out_valid}, fl);
    end
    if (!(mode[0] == 1 && kk[0] == 0)) begin
      checks++;
      assert (a_term_idx === eix) else begin
        errors++;
        $error("[TB] FAIL a_term_idx cyc=%0d observed=%0d expected=%0d", cyc, a_term_idx, eix);
      end
    end
    model_expect(1, fl, ix);
    eix = 3'(ix);
    checks++;
    assert ({b_ldX, b_ldTmp, b_selTmp, b_clrRes, b_ldRes, b_busy, b_out_valid} === fl) else begin
      errors++;
      $error("[TB] FAIL b_flags cyc=%0d observed=%b expected=%b", cyc,
             {b_ldX, b_ldTmp, b_selTmp, b_clrRes, b_ldRes, b_busy, b_out_valid}, fl);
    end
    if (!(mode[1] == 1 && kk[1] == 0)) begin
      checks++;
      assert (b_term_idx === eix) else begin
        errors++;
        $error("[TB] FAIL b_term_idx cyc=%0d observed=%0d expected=%0d", cyc, b_term_idx, eix);
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic tz, input logic rs);
    start     = s;
    out_ready = r;
    term_zero = tz;
    rst       = rs;
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int ldres_cnt, ov_a, ov_b, seen;
    logic tz, rs, s, did_rst, restarted;
    mode = '{0, 0};
    kk   = '{0, 0};
    midx = '{0, 0};
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; term_zero = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    // Nominal run; term_zero raised in the ADD of term 2 on the 8-term instance.
    applyStimulus(1, 1, 0, 0);
    cyc = 1;
    ldres_cnt = 0; ov_a = -1; ov_b = -1;
    for (int c = 1; c <= 25; c++) begin
      if (a_ldRes) ldres_cnt++;
      if (a_out_valid && ov_a < 0) ov_a = cyc;
      if (b_out_valid && ov_b < 0) ov_b = cyc;
      tz = (mode[0] == 1 && kk[0] == 6);
      applyStimulus(0, 1, tz, 0);
    end
    checks++;
    assert (ldres_cnt === (EARLY ? 3 : 8)) else begin
      errors++;
      $error("[TB] FAIL a_ldres_count observed=%0d expected=%0d", ldres_cnt, EARLY ? 3 : 8);
    end
    checks++;
    assert (ov_a === (EARLY ? 8 : 18)) else begin
      errors++;
      $error("[TB] FAIL a_valid_cycle observed=%0d expected=%0d", ov_a, EARLY ? 8 : 18);
    end
    checks++;
    assert (ov_b === 18) else begin
      errors++;
      $error("[TB] FAIL b_valid_cycle observed=%0d expected=%0d", ov_b, 18);
    end

    // Backpressure: out_ready low for the first five OUT cycles.
    applyStimulus(1, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_out_valid) seen++;
      applyStimulus(0, (seen > 5) || (seen > 0 && !a_out_valid), 0, 0);
    end

    // start held high across runs.
    for (int c = 0; c < 45; c++) applyStimulus(1, 1, 0, 0);
    for (int c = 0; c < 25; c++) applyStimulus(0, 1, 0, 0);

    // Reset in the third MUL, a mid-run start pulse, then a fresh nominal run.
    applyStimulus(1, 1, 0, 0);
    did_rst = 1'b0;
    restarted = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rs = !did_rst && mode[0] == 1 && kk[0] == 5;
      s  = (!did_rst && mode[0] == 1 && kk[0] == 3) || (did_rst && !restarted && !rs);
      if (did_rst && s) restarted = 1'b1;
      if (rs) did_rst = 1'b1;
      applyStimulus(s, 1, 0, rs);
    end

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 9) < 2), ($urandom_range(0, 99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
